operational_unit: RTL and testbench
===================================

Name: operational_unit

Overview:
- Datapath stage directly downstream of the microprogrammed control unit.
- Consumes the 17-bit control word each cycle and executes register-file/ALU micro-operations.
- Returns registered carry_flag/zero_flag, which the control unit uses for conditional jumps.
- Contains a 4-entry register file, an ALU, a flags register, an input-load path and a registered output port.

Parameters:
- WIDTH, 8, data width of registers, ALU, in_data and out_data.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- control_bus  input  17  micro-operation word from control unit; all-zero = NOP
- in_data  input  WIDTH  external operand, sampled when IN_LOAD=1
- in_ack  output  1  registered pulse, high one cycle after in_data was consumed
- out_data  output  WIDTH  registered output value
- out_valid  output  1  registered pulse, high one cycle after out_data was updated
- carry_flag  output  1  registered carry/borrow flag
- zero_flag  output  1  registered zero flag

Behaviour:
- Control word fields:
  - [16] REG_WE
  - [15:14] DST
  - [13:12] SRC_A
  - [11:10] SRC_B
  - [9] USE_CIN
  - [8:6] ALU_OP
  - [5] FLAGS_WE
  - [4] IN_LOAD
  - [3] OUT_WE
  - [2] CLR_FLAGS
  - [1:0] reserved, ignored
- ALU_OP encoding:
  - 000 ADD: R=A+B+(USE_CIN?C:0); carry = carry-out of the WIDTH+1-bit sum.
  - 001 SUB: R=A-B-(USE_CIN?C:0); carry = borrow (1 when the unsigned result would be negative).
  - 010 AND, 011 OR, 100 XOR: carry result 0.
  - 101 PASS_A: R=A; carry result 0.
  - 110 SHL: R={A[W-2:0],0}; carry result A[W-1].
  - 111 SHR: R={0,A[W-1:1]}; carry result A[0].
- Zero result = (R == 0), computed on the truncated WIDTH-bit result.
- Operand reads are combinational from the register file.
- All writes occur at the rising edge of the cycle in which the control word is present.
- Read of a register being written in the same cycle returns the old value.
- Register write:
  - IN_LOAD=1: reg[DST] <= in_data. This applies regardless of REG_WE and has priority over the ALU result.
  - else REG_WE=1: reg[DST] <= R.
  - else: no write.
- in_ack: registered copy of IN_LOAD, a one-cycle pulse per IN_LOAD cycle. Back-to-back IN_LOAD cycles give a continuously high in_ack.
- OUT_WE=1: out_data <= R (ALU result, never in_data); out_valid <= 1 next cycle. Otherwise out_valid <= 0 and out_data holds its value.
- Flags:
  - CLR_FLAGS=1: C<=0, Z<=0; overrides FLAGS_WE.
  - else FLAGS_WE=1: C, Z <= ALU carry/zero results, even when IN_LOAD is set.
  - else: flags hold.
- Flags are visible to the control unit from the cycle after the updating micro-operation. A jump word must therefore follow the flag-setting word by at least one word; jump words arrive as all-zero control words, so the datapath is idle during them.
- NOP (control_bus==0): no state change except in_ack/out_valid falling to 0.
- reset=1 at a rising edge:
  - all four registers, out_data, carry_flag and zero_flag go to 0; in_ack and out_valid go to 0.
  - the control_bus of that cycle is ignored.
  - reset mid-sequence discards any pending pulse.
- No internal state machine beyond register state; no stalls; a control word is fully executed in one cycle.

Optional Feature:
- Macro: OPERATIONAL_UNIT_OVERFLOW_EN.
- Defined:
  - Adds output port overflow_flag (1 bit), a registered signed-overflow flag.
  - For ADD/SUB it is set to two's-complement overflow of R; for all other ops it is set to 0.
  - Updated, cleared and reset exactly like carry_flag (FLAGS_WE, CLR_FLAGS, reset).
- Undefined: port absent; no overflow logic.

Test Plan:
- Reset, then one NOP: regs, out_data, flags all 0; in_ack=0, out_valid=0.
- IN_LOAD DST=0 with in_data=0xC8; IN_LOAD DST=1 with in_data=0x64; ADD A=0 B=1 DST=2 FLAGS_WE OUT_WE → reg2=0x2C, carry=1, zero=0, out_data=0x2C, out_valid pulses once, in_ack high two cycles.
- Sequence continues: SUB A=2 B=2 DST=3 FLAGS_WE → reg3=0x00, zero=1, carry=0. Then ADD A=0 B=1 with USE_CIN after setting C=1 → R=0x2D.
- reg0=0x01: SUB A=0 B=1 (reg1=0x02) FLAGS_WE → carry=1 (borrow), R=0xFF, zero=0. SHR of 0x81 → R=0x40, carry=1.
- FLAGS_WE and CLR_FLAGS asserted together on ADD producing zero → C=0, Z=0. IN_LOAD and REG_WE asserted together → in_data written, not R.
- reset asserted in the cycle after an OUT_WE → out_valid=0, out_data=0 on the next edge. With the macro: ADD 0x7F+0x01 → overflow_flag=1; AND → overflow_flag=0.

Source files
------------

// File: rtl/operational_unit_if.sv
// Control/data bus between the microprogrammed control unit (master) and the operational unit (slave).
// OPERATIONAL_UNIT_OVERFLOW_EN adds the overflow_flag signal.
interface operational_unit_if #(
  parameter int unsigned WIDTH = 8
);
  logic [16:0]      control_bus;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             carry_flag;
  logic             zero_flag;
`ifdef OPERATIONAL_UNIT_OVERFLOW_EN
  logic             overflow_flag;
`endif

  modport master (
    output control_bus,
    output in_data,
    input  in_ack,
    input  out_data,
    input  out_valid,
`ifdef OPERATIONAL_UNIT_OVERFLOW_EN
    input  overflow_flag,
`endif
    input  carry_flag,
    input  zero_flag
  );

  modport slave (
    input  control_bus,
    input  in_data,
    output in_ack,
    output out_data,
    output out_valid,
`ifdef OPERATIONAL_UNIT_OVERFLOW_EN
    output overflow_flag,
`endif
    output carry_flag,
    output zero_flag
  );
endinterface

// File: rtl/operational_unit.sv
// Datapath executing one 17-bit micro-operation word per cycle: 4-entry register file, ALU, flags, I/O.
// Optional macro OPERATIONAL_UNIT_OVERFLOW_EN adds a registered signed-overflow flag.
module operational_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  operational_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    ALU_ADD    = 3'b000,
    ALU_SUB    = 3'b001,
    ALU_AND    = 3'b010,
    ALU_OR     = 3'b011,
    ALU_XOR    = 3'b100,
    ALU_PASS_A = 3'b101,
    ALU_SHL    = 3'b110,
    ALU_SHR    = 3'b111
  } alu_op_e;

  logic       reg_we;
  logic [1:0] dst;
  logic [1:0] src_a;
  logic [1:0] src_b;
  logic       use_cin;
  alu_op_e    alu_op;
  logic       flags_we;
  logic       in_load;
  logic       out_we;
  logic       clr_flags;

  assign reg_we    = bus.control_bus[16];
  assign dst       = bus.control_bus[15:14];
  assign src_a     = bus.control_bus[13:12];
  assign src_b     = bus.control_bus[11:10];
  assign use_cin   = bus.control_bus[9];
  assign alu_op    = alu_op_e'(bus.control_bus[8:6]);
  assign flags_we  = bus.control_bus[5];
  assign in_load   = bus.control_bus[4];
  assign out_we    = bus.control_bus[3];
  assign clr_flags = bus.control_bus[2];

  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ack_q, in_ack_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH:0]   cin_ext;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_z;

  // Operands come from the pre-edge register contents, so a same-cycle write is not forwarded.
  assign op_a     = regs_q[src_a];
  assign op_b     = regs_q[src_b];
  assign cin_ext  = {{WIDTH{1'b0}}, use_cin & carry_q};
  assign sum_ext  = {1'b0, op_a} + {1'b0, op_b} + cin_ext;
  assign diff_ext = {1'b0, op_a} - {1'b0, op_b} - cin_ext;

  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_r = sum_ext[WIDTH-1:0];
        alu_c = sum_ext[WIDTH];
      end
      ALU_SUB: begin
        // Top bit of the wrapped WIDTH+1-bit difference is the borrow.
        alu_r = diff_ext[WIDTH-1:0];
        alu_c = diff_ext[WIDTH];
      end
      ALU_AND:    alu_r = op_a & op_b;
      ALU_OR:     alu_r = op_a | op_b;
      ALU_XOR:    alu_r = op_a ^ op_b;
      ALU_PASS_A: alu_r = op_a;
      ALU_SHL: begin
        alu_r = {op_a[WIDTH-2:0], 1'b0};
        alu_c = op_a[WIDTH-1];
      end
      ALU_SHR: begin
        alu_r = {1'b0, op_a[WIDTH-1:1]};
        alu_c = op_a[0];
      end
      default: begin
        alu_r = '0;
        alu_c = 1'b0;
      end
    endcase
  end

  assign alu_z = (alu_r == '0);

`ifdef OPERATIONAL_UNIT_OVERFLOW_EN
  logic alu_v;
  logic ovf_q, ovf_d;

  always_comb begin
    alu_v = 1'b0;
    case (alu_op)
      ALU_ADD: alu_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
      ALU_SUB: alu_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (alu_r[WIDTH-1] != op_a[WIDTH-1]);
      default: alu_v = 1'b0;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (clr_flags) begin
      ovf_d = 1'b0;
    end else if (flags_we) begin
      ovf_d = alu_v;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.overflow_flag = ovf_q;
`endif

  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
    end
    // External load wins over the ALU result when both target the register file.
    if (in_load) begin
      regs_d[dst] = bus.in_data;
    end else if (reg_we) begin
      regs_d[dst] = alu_r;
    end

    in_ack_d    = in_load;
    out_valid_d = out_we;
    out_data_d  = out_we ? alu_r : out_data_q;

    carry_d = carry_q;
    zero_d  = zero_q;
    if (clr_flags) begin
      carry_d = 1'b0;
      zero_d  = 1'b0;
    end else if (flags_we) begin
      carry_d = alu_c;
      zero_d  = alu_z;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      in_ack_q    <= 1'b0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      in_ack_q    <= in_ack_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
    end
  end

  assign bus.in_ack     = in_ack_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.carry_flag = carry_q;
  assign bus.zero_flag  = zero_q;

endmodule

// File: tb/tb_operational_unit.sv
// Directed bench for operational_unit: hand-computed micro-operation sequences checked with immediate assertions.
// Overflow checks are compiled in when OPERATIONAL_UNIT_OVERFLOW_EN is defined.
module tb_operational_unit;

  localparam int unsigned WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_PAS = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  operational_unit_if #(.WIDTH(WIDTH)) bus_if ();

  operational_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [16:0] cw(input logic rw, input logic [1:0] d, input logic [1:0] a,
                                     input logic [1:0] b, input logic ci, input logic [2:0] op,
                                     input logic fw, input logic il, input logic ow, input logic cl);
    return {rw, d, a, b, ci, op, fw, il, ow, cl, 2'b00};
  endfunction

  // Present one word for one rising edge, then sample 1 time unit after it.
  task automatic step(input logic rst, input logic [16:0] word, input logic [WIDTH-1:0] din);
    @(negedge clock);
    reset               = rst;
    bus_if.control_bus  = word;
    bus_if.in_data      = din;
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, input logic [WIDTH-1:0] exp, input string tag);
    step(1'b0, cw(0, 2'd0, idx, 2'd0, 0, OP_PAS, 0, 0, 1, 0), 8'h00);
    check(tag, {24'h0, bus_if.out_data}, {24'h0, exp});
  endtask

  initial begin
    errors             = 0;
    checks             = 0;
    reset              = 1'b1;
    bus_if.control_bus = '0;
    bus_if.in_data     = '0;

    // Reset with a busy word present: that word must be ignored.
    step(1'b1, cw(1, 2'd0, 2'd0, 2'd0, 0, OP_ADD, 1, 1, 1, 0), 8'hAA);
    step(1'b1, '0, 8'h00);
    step(1'b0, '0, 8'h00);
    check("rst_in_ack",    {31'h0, bus_if.in_ack},     32'h0);
    check("rst_out_valid", {31'h0, bus_if.out_valid},  32'h0);
    check("rst_out_data",  {24'h0, bus_if.out_data},   32'h0);
    check("rst_carry",     {31'h0, bus_if.carry_flag}, 32'h0);
    check("rst_zero",      {31'h0, bus_if.zero_flag},  32'h0);
    read_reg(2'd0, 8'h00, "rst_reg0");
    check("pass_out_valid", {31'h0, bus_if.out_valid}, 32'h1);
    read_reg(2'd1, 8'h00, "rst_reg1");
    read_reg(2'd2, 8'h00, "rst_reg2");
    read_reg(2'd3, 8'h00, "rst_reg3");

    // Two loads, then ADD with carry out.
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'hC8);
    check("ld0_in_ack", {31'h0, bus_if.in_ack}, 32'h1);
    step(1'b0, cw(0, 2'd1, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h64);
    check("ld1_in_ack", {31'h0, bus_if.in_ack}, 32'h1);
    step(1'b0, cw(1, 2'd2, 2'd0, 2'd1, 0, OP_ADD, 1, 0, 1, 0), 8'h00);
    check("add_out_data",  {24'h0, bus_if.out_data},   32'h2C);
    check("add_out_valid", {31'h0, bus_if.out_valid},  32'h1);
    check("add_carry",     {31'h0, bus_if.carry_flag}, 32'h1);
    check("add_zero",      {31'h0, bus_if.zero_flag},  32'h0);
    check("add_in_ack",    {31'h0, bus_if.in_ack},     32'h0);
    step(1'b0, '0, 8'h00);
    check("nop_out_valid", {31'h0, bus_if.out_valid}, 32'h0);
    check("nop_out_hold",  {24'h0, bus_if.out_data},  32'h2C);
    read_reg(2'd2, 8'h2C, "reg2_sum");

    // SUB to zero.
    step(1'b0, cw(1, 2'd3, 2'd2, 2'd2, 0, OP_SUB, 1, 0, 0, 0), 8'h00);
    check("sub0_zero",  {31'h0, bus_if.zero_flag},  32'h1);
    check("sub0_carry", {31'h0, bus_if.carry_flag}, 32'h0);
    read_reg(2'd3, 8'h00, "reg3_zero");

    // Set C=1, then ADD with carry-in.
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd1, 0, OP_ADD, 1, 0, 0, 0), 8'h00);
    check("setc_carry", {31'h0, bus_if.carry_flag}, 32'h1);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd1, 1, OP_ADD, 0, 0, 1, 0), 8'h00);
    check("adc_out_data", {24'h0, bus_if.out_data}, 32'h2D);

    // Borrow: 0x01 - 0x02.
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h01);
    step(1'b0, cw(0, 2'd1, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h02);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd1, 0, OP_SUB, 1, 0, 1, 0), 8'h00);
    check("borrow_out",   {24'h0, bus_if.out_data},   32'hFF);
    check("borrow_carry", {31'h0, bus_if.carry_flag}, 32'h1);
    check("borrow_zero",  {31'h0, bus_if.zero_flag},  32'h0);

    // Shifts of 0x81.
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h81);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_SHR, 1, 0, 1, 0), 8'h00);
    check("shr_out",   {24'h0, bus_if.out_data},   32'h40);
    check("shr_carry", {31'h0, bus_if.carry_flag}, 32'h1);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_SHL, 1, 0, 1, 0), 8'h00);
    check("shl_out",   {24'h0, bus_if.out_data},   32'h02);
    check("shl_carry", {31'h0, bus_if.carry_flag}, 32'h1);

    // CLR_FLAGS overrides FLAGS_WE on a zero result.
    step(1'b0, cw(0, 2'd0, 2'd3, 2'd3, 0, OP_ADD, 1, 0, 0, 1), 8'h00);
    check("clr_carry", {31'h0, bus_if.carry_flag}, 32'h0);
    check("clr_zero",  {31'h0, bus_if.zero_flag},  32'h0);

    // IN_LOAD beats REG_WE; out_data still takes the ALU result (0x81+0x81).
    step(1'b0, cw(1, 2'd2, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 1, 0), 8'h5A);
    check("ldwe_out_r",  {24'h0, bus_if.out_data}, 32'h02);
    check("ldwe_in_ack", {31'h0, bus_if.in_ack},   32'h1);
    read_reg(2'd2, 8'h5A, "ldwe_reg2");

    // Self-update reads the old value: 0x5A + 0x5A.
    step(1'b0, cw(1, 2'd2, 2'd2, 2'd2, 0, OP_ADD, 0, 0, 1, 0), 8'h00);
    check("self_out", {24'h0, bus_if.out_data}, 32'hB4);
    read_reg(2'd2, 8'hB4, "self_reg2");

    // Borrow again (0x81 - 0xB4), then output, then reset on the next cycle.
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd2, 0, OP_SUB, 1, 0, 0, 0), 8'h00);
    check("pre_rst_carry", {31'h0, bus_if.carry_flag}, 32'h1);
    read_reg(2'd2, 8'hB4, "pre_rst_out");
    step(1'b1, cw(1, 2'd1, 2'd0, 2'd0, 0, OP_ADD, 1, 1, 1, 0), 8'h33);
    check("mid_rst_valid",  {31'h0, bus_if.out_valid},  32'h0);
    check("mid_rst_out",    {24'h0, bus_if.out_data},   32'h0);
    check("mid_rst_carry",  {31'h0, bus_if.carry_flag}, 32'h0);
    check("mid_rst_in_ack", {31'h0, bus_if.in_ack},     32'h0);
    read_reg(2'd2, 8'h00, "mid_rst_reg2");
    read_reg(2'd1, 8'h00, "mid_rst_reg1");

`ifdef OPERATIONAL_UNIT_OVERFLOW_EN
    check("rst_ovf", {31'h0, bus_if.overflow_flag}, 32'h0);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h7F);
    step(1'b0, cw(0, 2'd1, 2'd0, 2'd0, 0, OP_ADD, 0, 1, 0, 0), 8'h01);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd1, 0, OP_ADD, 1, 0, 1, 0), 8'h00);
    check("ovf_add",     {31'h0, bus_if.overflow_flag}, 32'h1);
    check("ovf_add_out", {24'h0, bus_if.out_data},      32'h80);
    check("ovf_add_c",   {31'h0, bus_if.carry_flag},    32'h0);
    step(1'b0, cw(0, 2'd0, 2'd0, 2'd1, 0, OP_AND, 1, 0, 1, 0), 8'h00);
    check("ovf_and",     {31'h0, bus_if.overflow_flag}, 32'h0);
    check("ovf_and_out", {24'h0, bus_if.out_data},      32'h01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
